load_counter: RTL

//  Loadable up-counter sitting directly downstream of the 8-bit 2:1 data multiplexer.
//  The mux output feeds data; count drives the next address/sequence stage.

---
 rtl/counter_pkg.sv | 13 +
 rtl/load_counter.sv | 65 ++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the loadable up-counter.
// Controller states and the two step sizes the counter can advance by.
package counter_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctr_state_e;

  localparam int STEP_ONE  = 1;
  localparam int STEP_SKIP = 2;

endpackage

// File: rtl/load_counter.sv
// Loadable up-counter with +1/+2 stepping, terminal-count flag and a
// RUN/HALTED controller that freezes the count until resumed.
module load_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             skip,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running
);

  localparam logic [WIDTH-1:0] STEP_ONE_W  = WIDTH'(STEP_ONE);
  localparam logic [WIDTH-1:0] STEP_SKIP_W = WIDTH'(STEP_SKIP);

  ctr_state_e       state_reg;
  logic [WIDTH-1:0] count_reg;
  logic             running_reg;

  // halt outranks load/enable; resume alone only changes state, so the
  // count is untouched for the whole time spent in HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      count_reg   <= '0;
      running_reg <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (halt) begin
            state_reg   <= HALTED;
            running_reg <= 1'b0;
          end else if (load) begin
            count_reg <= data;
          end else if (enable) begin
            count_reg <= count_reg + (skip ? STEP_SKIP_W : STEP_ONE_W);
          end
        end
        HALTED: begin
          if (resume && !halt) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= RUN;
          running_reg <= 1'b1;
        end
      endcase
    end
  end

  assign count   = count_reg;
  assign tc      = &count_reg;
  assign running = running_reg;

endmodule
